machine_csr_unit: RTL
=====================

MACHINE_CSR_UNIT -- requirements
Module: machine_csr_unit

Interface
REQ-001 SHALL have parameter NUM_LOCAL_IRQ, default 4, meaning the number of platform interrupts (1..16) mapped to mip/mie bits 16+i.
REQ-002 SHALL have parameter MTVEC_RESET, default 32'h0, meaning the mtvec reset value.
REQ-003 SHALL have parameter HART_ID, default 0, meaning the mhartid (0xF14) read value.
REQ-004 SHALL have ports (name, direction, width, meaning):
 clk  in  1  clock;
 reset  in  1  asynchronous, active-high;
 csr_addr  in  12  CSR address;
 csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear);
 csr_wdata  in  32  rs1/imm operand;
 csr_rdata  out  32  old CSR value, combinational;
 csr_illegal  out  1  access illegal, combinational;
 trap_en  in  1  take trap this cycle;
 trap_pc, trap_cause, trap_val  in  32 each  mepc/mcause/mtval sources;
 is_mret  in  1  mret retiring;
 instr_retire  in  1  one instruction retired;
 ext_int, sw_int, timer_int  in  1 each  MEIP/MSIP/MTIP sources;
 local_int  in  NUM_LOCAL_IRQ  platform interrupt sources;
 mepc_out  out  32  mepc;
 trap_vector  out  32  redirect target for trap_cause;
 irq_req  out  1  enabled interrupt pending;
 irq_cause  out  32  mcause value of the highest-priority pending interrupt.

Function
REQ-005 SHALL implement mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mcountinhibit 0x320, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, and mvendorid/marchid/mimpid/mhartid 0xF11-0xF14.
REQ-006 Write value SHALL be wdata (RW), old|wdata (RS), or old&~wdata (RC); RS/RC with csr_wdata==0 SHALL perform no write.
REQ-007 csr_illegal SHALL assert when csr_op!=00 and the address is unimplemented, or when a write is performed to 0xF11-0xF14; an illegal access SHALL change no state and SHALL return csr_rdata=0.
REQ-008 mstatus SHALL implement only MIE[3] and MPIE[7] as writable; MPP[12:11] SHALL read 2'b11; all other bits SHALL read 0.
REQ-009 misa SHALL read 32'h40000100, with writes ignored and not illegal; 0xF11-0xF13 SHALL read 0; 0xF14 SHALL read HART_ID.
REQ-010 mie SHALL store only bits 3, 7, 11 and 16..16+NUM_LOCAL_IRQ-1; all other bits SHALL read 0.
REQ-011 mip SHALL register ext_int->bit11, timer_int->bit7, sw_int->bit3 and local_int[i]->bit16+i every cycle (one-cycle latency); mip SHALL be read-only, with writes ignored and not illegal.
REQ-012 mtvec[1:0] SHALL hold mode (0 direct, 1 vectored); a written mode of 2 or 3 SHALL store 0; mepc[1:0] SHALL always read 0.
REQ-013 trap_vector SHALL equal {mtvec[31:2],2'b00} + 4*trap_cause[4:0] when mode=1 and trap_cause[31]=1, and {mtvec[31:2],2'b00} otherwise.
REQ-014 Pending set P = mip & mie; irq_req SHALL equal mstatus.MIE & |P.
REQ-015 irq_cause SHALL be {1'b1, code} using priority MEI(11) > MSI(3) > MTI(7) > local, highest index first; irq_cause SHALL be 0 when P==0.
REQ-016 On trap_en: mepc<=trap_pc, mcause<=trap_cause, mtval<=trap_val, MPIE<=MIE, MIE<=0.
REQ-017 On is_mret without trap_en: MIE<=MPIE, MPIE<=1.
REQ-018 Precedence SHALL be trap_en > is_mret > CSR write; a lower-precedence update in the same cycle SHALL be discarded.
REQ-019 mcycle (64-bit) SHALL increment every cycle unless mcountinhibit[0]=1; minstret (64-bit) SHALL increment on instr_retire unless mcountinhibit[2]=1; both SHALL wrap from all-ones to 0.
REQ-020 A CSR write to a counter half SHALL override that cycle's increment for the whole 64-bit counter: the written half takes the new value and the other half holds.
REQ-021 mcountinhibit SHALL implement only bits 0 and 2.
REQ-022 Counter increments SHALL continue in cycles with trap_en or is_mret asserted.

Reset
REQ-023 On reset, mtvec SHALL be MTVEC_RESET; mstatus SHALL be 32'h1800; mepc, mcause, mtval, mscratch, mie, mip, mcountinhibit, mcycle and minstret SHALL be 0.
REQ-024 During reset, irq_req SHALL be 0 and irq_cause SHALL be 0, and reset asserted mid-operation SHALL take effect immediately.

Verification
REQ-025 Write mtvec=0x1001, set mie bit7 and MIE, pulse timer_int -> irq_req=1 two cycles after the pulse edge, irq_cause=0x80000007; with trap_cause=0x80000007, trap_vector=0x101C.
REQ-026 Raise ext_int, timer_int and local_int[2] together with all enabled -> irq_cause=0x8000000B; drop ext_int -> 0x80000007.
REQ-027 trap_en and csr RW to mstatus in the same cycle -> the write is lost, MIE=0, MPIE=old MIE; a following mret -> MIE restored, MPIE=1.
REQ-028 Write mcycle=0xFFFFFFFF, mcycleh=0xFFFFFFFF, then run one cycle -> counter reads 0/0; set mcountinhibit=0x5 -> both counters frozen.
REQ-029 RW to 0xF14 -> csr_illegal=1, no change; RS to 0xF14 with wdata 0 -> legal, rdata=HART_ID; RW to 0x7C0 -> illegal, rdata=0.
REQ-030 Assert reset mid-count with irq_req high -> all registers take their REQ-023 values asynchronously and irq_req=0.

Source files
------------

// File: rtl/machine_csr_unit.sv
// Machine-mode CSR file: trap/mret state, interrupt pending/enable and
// priority, 64-bit cycle/instret counters and the trap vector computation.
module machine_csr_unit #(
    parameter int unsigned NUM_LOCAL_IRQ = 4,
    parameter logic [31:0] MTVEC_RESET   = 32'h0,
    parameter logic [31:0] HART_ID       = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [11:0]              csr_addr,
    input  logic [1:0]               csr_op,
    input  logic [31:0]              csr_wdata,
    output logic [31:0]              csr_rdata,
    output logic                     csr_illegal,
    input  logic                     trap_en,
    input  logic [31:0]              trap_pc,
    input  logic [31:0]              trap_cause,
    input  logic [31:0]              trap_val,
    input  logic                     is_mret,
    input  logic                     instr_retire,
    input  logic                     ext_int,
    input  logic                     sw_int,
    input  logic                     timer_int,
    input  logic [NUM_LOCAL_IRQ-1:0] local_int,
    output logic [31:0]              mepc_out,
    output logic [31:0]              trap_vector,
    output logic                     irq_req,
    output logic [31:0]              irq_cause
);

    localparam logic [31:0] MISA_VAL  = 32'h4000_0100;
    localparam logic [31:0] LOCAL_MSK = ((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16;
    localparam logic [31:0] MIE_MASK  = 32'h0000_0888 | LOCAL_MSK;
    localparam logic [31:0] CINH_MASK = 32'h0000_0005;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MCINH    = 12'h320;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTR   = 12'hB02;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_MVENDOR  = 12'hF11;
    localparam logic [11:0] A_MARCH    = 12'hF12;
    localparam logic [11:0] A_MIMP     = 12'hF13;
    localparam logic [11:0] A_MHART    = 12'hF14;

    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mcinh_q, mcinh_d;
    logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d, mip_q, mip_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic        irq_req_q, irq_req_d;
    logic [31:0] irq_cause_q, irq_cause_d;

    logic [31:0] rdata_raw, wval, pend, tvec_base;
    logic        csr_impl, csr_write, wr_en;

    // Read mux over the implemented address map
    always_comb begin
        rdata_raw = 32'h0;
        csr_impl  = 1'b1;
        case (csr_addr)
            A_MSTATUS:  rdata_raw = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
            A_MISA:     rdata_raw = MISA_VAL;
            A_MIE:      rdata_raw = mie_q;
            A_MTVEC:    rdata_raw = mtvec_q;
            A_MCINH:    rdata_raw = mcinh_q;
            A_MSCRATCH: rdata_raw = mscratch_q;
            A_MEPC:     rdata_raw = mepc_q;
            A_MCAUSE:   rdata_raw = mcause_q;
            A_MTVAL:    rdata_raw = mtval_q;
            A_MIP:      rdata_raw = mip_q;
            A_MCYCLE:   rdata_raw = mcycle_q[31:0];
            A_MCYCLEH:  rdata_raw = mcycle_q[63:32];
            A_MINSTR:   rdata_raw = minstret_q[31:0];
            A_MINSTRH:  rdata_raw = minstret_q[63:32];
            A_MVENDOR, A_MARCH, A_MIMP: rdata_raw = 32'h0;
            A_MHART:    rdata_raw = HART_ID;
            default:    csr_impl  = 1'b0;
        endcase
    end

    // Access legality and the value a write would store
    always_comb begin
        csr_write   = (csr_op == 2'b01) || (csr_op[1] && (csr_wdata != 32'h0));
        csr_illegal = (csr_op != 2'b00) &&
                      (!csr_impl || (csr_write && csr_addr >= A_MVENDOR && csr_addr <= A_MHART));
        csr_rdata   = csr_illegal ? 32'h0 : rdata_raw;
        wr_en       = csr_write && !csr_illegal && !trap_en && !is_mret;
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = rdata_raw | csr_wdata;
            2'b11:   wval = rdata_raw & ~csr_wdata;
            default: wval = rdata_raw;
        endcase
    end

    // Trap redirect target, vectored only for interrupt causes
    always_comb begin
        tvec_base = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && trap_cause[31])
            trap_vector = tvec_base + {25'b0, trap_cause[4:0], 2'b00};
        else
            trap_vector = tvec_base;
    end

    // Next state: counters, pending sampling, then trap > mret > CSR write
    always_comb begin
        mst_mie_d   = mst_mie_q;
        mst_mpie_d  = mst_mpie_q;
        mie_d       = mie_q;
        mtvec_d     = mtvec_q;
        mcinh_d     = mcinh_q;
        mscratch_d  = mscratch_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        mcycle_d    = mcinh_q[0] ? mcycle_q : mcycle_q + 64'd1;
        minstret_d  = (instr_retire && !mcinh_q[2]) ? minstret_q + 64'd1 : minstret_q;

        mip_d                       = 32'h0;
        mip_d[11]                   = ext_int;
        mip_d[7]                    = timer_int;
        mip_d[3]                    = sw_int;
        mip_d[16 +: NUM_LOCAL_IRQ]  = local_int;

        pend        = mip_q & mie_q;
        irq_req_d   = mst_mie_q && (pend != 32'h0);
        irq_cause_d = 32'h0;
        for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++)
            if (pend[16 + i]) irq_cause_d = 32'h8000_0000 | 32'(16 + i);
        if (pend[7])  irq_cause_d = 32'h8000_0007;
        if (pend[3])  irq_cause_d = 32'h8000_0003;
        if (pend[11]) irq_cause_d = 32'h8000_000B;

        if (trap_en) begin
            mepc_d     = {trap_pc[31:2], 2'b00};
            mcause_d   = trap_cause;
            mtval_d    = trap_val;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (is_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mst_mie_d  = wval[3];
                    mst_mpie_d = wval[7];
                end
                A_MIE:      mie_d      = wval & MIE_MASK;
                A_MTVEC:    mtvec_d    = {wval[31:2], 1'b0, (wval[1:0] == 2'b01)};
                A_MCINH:    mcinh_d    = wval & CINH_MASK;
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d     = {wval[31:2], 2'b00};
                A_MCAUSE:   mcause_d   = wval;
                A_MTVAL:    mtval_d    = wval;
                A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wval};
                A_MCYCLEH:  mcycle_d   = {wval, mcycle_q[31:0]};
                A_MINSTR:   minstret_d = {minstret_q[63:32], wval};
                A_MINSTRH:  minstret_d = {wval, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mst_mie_q   <= 1'b0;
            mst_mpie_q  <= 1'b0;
            mie_q       <= 32'h0;
            mtvec_q     <= MTVEC_RESET;
            mcinh_q     <= 32'h0;
            mscratch_q  <= 32'h0;
            mepc_q      <= 32'h0;
            mcause_q    <= 32'h0;
            mtval_q     <= 32'h0;
            mip_q       <= 32'h0;
            mcycle_q    <= 64'h0;
            minstret_q  <= 64'h0;
            irq_req_q   <= 1'b0;
            irq_cause_q <= 32'h0;
        end else begin
            mst_mie_q   <= mst_mie_d;
            mst_mpie_q  <= mst_mpie_d;
            mie_q       <= mie_d;
            mtvec_q     <= mtvec_d;
            mcinh_q     <= mcinh_d;
            mscratch_q  <= mscratch_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            mip_q       <= mip_d;
            mcycle_q    <= mcycle_d;
            minstret_q  <= minstret_d;
            irq_req_q   <= irq_req_d;
            irq_cause_q <= irq_cause_d;
        end
    end

    assign mepc_out  = mepc_q;
    assign irq_req   = irq_req_q;
    assign irq_cause = irq_cause_q;

endmodule
